// File: rtl/sync_fifo_param_buffer_if.sv
// Bus bundle for sync_fifo_param_buffer: the write/read handshakes, the error clear and
// the status outputs. The producer/consumer side uses master, the FIFO uses slave.
interface sync_fifo_param_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  wr_cs;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_cs;
    logic                  rd_en;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   fill_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_cs, wr_en, data_in, rd_cs, rd_en, clr_err,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               fill_count, overflow, underflow
    );

    modport slave (
        input  wr_cs, wr_en, data_in, rd_cs, rd_en, clr_err,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               fill_count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param_buffer.sv
// Single-clock input-buffer FIFO with guarded push/pop, thresholds, occupancy count,
// sticky overflow/underflow flags and a selectable registered or fall-through read.
module sync_fifo_param_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned AF_THRESH  = 56,
    parameter int unsigned AE_THRESH  = 8,
    parameter bit          FWFT       = 1'b0
) (
    input logic                     clk,
    input logic                     rst,
    sync_fifo_param_buffer_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AfCnt    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   AeCnt    = (ADDR_WIDTH + 1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0]   CntOne   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PtrOne   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  push_req, pop_req, push_ok, pop_ok, full, empty;

    // Accept decisions use the pre-edge full/empty so push+pop on a full or empty
    // FIFO lets exactly one side through.
    always_comb begin
        push_req    = bus.wr_cs & bus.wr_en;
        pop_req     = bus.rd_cs & bus.rd_en;
        full        = (count_q == DepthCnt);
        empty       = (count_q == '0);
        push_ok     = push_req & ~full;
        pop_ok      = pop_req & ~empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrOne;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
        // A new rejection outranks a clear on the same edge.
        overflow_d  = (push_req & full)  | (overflow_q  & ~bus.clr_err);
        underflow_d = (pop_req  & empty) | (underflow_q & ~bus.clr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.data_in;
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AfCnt);
    assign bus.almost_empty = (count_q <= AeCnt);
    assign bus.fill_count   = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    if (!FWFT) begin : g_std_read
        logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
        logic                  data_valid_q, data_valid_d;

        always_comb begin
            data_out_d   = data_out_q;
            data_valid_d = pop_ok;
            if (pop_ok) data_out_d = mem_q[rd_ptr_q];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_out_q   <= '0;
                data_valid_q <= 1'b0;
            end else begin
                data_out_q   <= data_out_d;
                data_valid_q <= data_valid_d;
            end
        end

        assign bus.data_out   = data_out_q;
        assign bus.data_valid = data_valid_q;
    end else begin : g_fwft_read
        assign bus.data_out   = mem_q[rd_ptr_q];
        assign bus.data_valid = ~empty;
    end
endmodule
